// File: rtl/audio_dsp_pkg.sv
// Shared types and helpers for the audio DSP chain: sample/frequency widths,
// the per-frame record layout and saturating magnitude.
package audio_dsp_pkg;

  localparam int SAMPLE_W = 16;
  localparam int FREQ_W   = 16;
  localparam int FNUM_W   = 32;
  localparam int PEAK_W   = SAMPLE_W - 1;

  typedef struct packed {
    logic [FNUM_W-1:0] frame_num;
    logic [PEAK_W-1:0] peak;
    logic [FREQ_W-1:0] est_freq;
    logic [FREQ_W-1:0] target_freq;
  } frame_rec_t;

  // |x| with the most-negative code clamped to the largest positive magnitude.
  function automatic logic [PEAK_W-1:0] abs_sat(input logic signed [SAMPLE_W-1:0] x);
    if (!x[SAMPLE_W-1]) return PEAK_W'(x);
    if (x[PEAK_W-1:0] == '0) return '1;
    return PEAK_W'(~x + 1'b1);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO with occupancy count; a push while full is
// accepted only if a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         push_data_i,
  input  logic                     pop_i,
  output logic                     valid_o,
  output logic                     full_o,
  output logic [WIDTH-1:0]         head_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]      count_q, count_d;
  logic             push_ok, pop_ok;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    wr_d    = wr_q;
    rd_d    = rd_q;
    count_d = count_q;
    pop_ok  = pop_i && (count_q != '0);
    push_ok = push_i && ((count_q != (AW+1)'(DEPTH)) || pop_ok);
    if (push_ok) wr_d = wr_q + 1'b1;
    if (pop_ok)  rd_d = rd_q + 1'b1;
    unique case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
    end
  end

  // NOTE: storage is not reset; the head is masked while empty instead.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_q] <= push_data_i;
  end

  assign valid_o = (count_q != '0);
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign head_o  = valid_o ? mem[rd_q] : '0;
  assign count_o = count_q;

endmodule

// File: rtl/audio_frame_monitor.sv
// Splits the processed sample stream into fixed-size frames and queues one
// {frame number, peak |sample|, frequency snapshot} record per frame for the host.
module audio_frame_monitor
  import audio_dsp_pkg::*;
#(
  parameter int FRAME_SIZE = 1000,
  parameter int FIFO_DEPTH = 8,
  parameter int DROP_W     = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable,
  input  logic                          in_valid,
  input  logic signed [SAMPLE_W-1:0]    in_sample,
  input  logic        [FREQ_W-1:0]      est_freq,
  input  logic        [FREQ_W-1:0]      target_freq,
  output logic                          rec_valid,
  input  logic                          rec_ready,
  output logic        [FNUM_W-1:0]      rec_frame_num,
  output logic        [SAMPLE_W-2:0]    rec_peak,
  output logic        [FREQ_W-1:0]      rec_est_freq,
  output logic        [FREQ_W-1:0]      rec_target_freq,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic        [DROP_W-1:0]      dropped
);

  localparam int CNT_W = $clog2(FRAME_SIZE);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_SIZE - 1);

  logic [CNT_W-1:0]  count_q, count_d;
  logic [PEAK_W-1:0] peak_q, peak_d, peak_upd, mag;
  logic [FNUM_W-1:0] fnum_q, fnum_d;
  logic [DROP_W-1:0] drop_q, drop_d;
  logic              accept, closing, fifo_full, pop;
  frame_rec_t        rec_d, head;

  always_comb begin
    count_d  = count_q;
    peak_d   = peak_q;
    fnum_d   = fnum_q;
    drop_d   = drop_q;
    mag      = abs_sat(in_sample);
    accept   = enable && in_valid;
    closing  = accept && (count_q == LAST);
    // The first sample of a frame overrides whatever the previous frame left behind.
    peak_upd = ((count_q == '0) || (mag > peak_q)) ? mag : peak_q;
    if (accept) begin
      count_d = closing ? '0 : count_q + 1'b1;
      peak_d  = peak_upd;
    end
    if (closing) fnum_d = fnum_q + 1'b1;
    if (closing && fifo_full && !pop && (drop_q != '1)) drop_d = drop_q + 1'b1;
    rec_d = '{frame_num: fnum_q, peak: peak_upd, est_freq: est_freq, target_freq: target_freq};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      peak_q  <= '0;
      fnum_q  <= '0;
      drop_q  <= '0;
    end else begin
      count_q <= count_d;
      peak_q  <= peak_d;
      fnum_q  <= fnum_d;
      drop_q  <= drop_d;
    end
  end

  assign pop = rec_valid && rec_ready;

  sync_fifo #(
    .WIDTH ($bits(frame_rec_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_rec_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (closing),
    .push_data_i (rec_d),
    .pop_i       (rec_ready),
    .valid_o     (rec_valid),
    .full_o      (fifo_full),
    .head_o      (head),
    .count_o     (fifo_level)
  );

  assign rec_frame_num   = head.frame_num;
  assign rec_peak        = head.peak;
  assign rec_est_freq    = head.est_freq;
  assign rec_target_freq = head.target_freq;
  assign dropped         = drop_q;

endmodule
